tinycomp_io_ctrl: RTL and testbench



---
 rtl/tinycomp_io_pkg.sv | 14 +
 rtl/tinycomp_io_fifo.sv | 46 ++++
 rtl/tinycomp_io_ctrl.sv | 120 ++++++++++++
 tb/tb_tinycomp_io_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinycomp_io_pkg.sv
// Shared constants for the TinyComp I/O controller: status word layout,
// default status address and channel limit.
package tinycomp_io_pkg;

  localparam logic [3:0] STATUS_ADDR_DEFAULT = 4'hF;

  localparam int NONEMPTY_LSB = 0;
  localparam int NOTFULL_LSB  = 8;
  localparam int OVF_LSB      = 16;
  localparam int UNF_LSB      = 24;

  localparam int MAX_NCH = 8;

endpackage

// File: rtl/tinycomp_io_fifo.sv
// Register-array FIFO with a combinational head. A push while full and a pop
// while empty are both ignored; the head reads 0 when the FIFO is empty.
module tinycomp_io_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tinycomp_io_ctrl.sv
// I/O controller between the TinyComp core I/O port and NCH streaming
// peripherals: address decode, read mux, sticky error flags, per-channel FIFOs.
module tinycomp_io_ctrl
  import tinycomp_io_pkg::*;
#(
  parameter int         NCH         = 2,
  parameter int         DEPTH       = 4,
  parameter logic [3:0] STATUS_ADDR = STATUS_ADDR_DEFAULT
) (
  input  logic              Ph0,
  input  logic              Reset_n,
  input  logic [31:0]       IOaddr,
  input  logic              InStrobe,
  output logic [31:0]       InData,
  output logic              InRdy,
  input  logic              OutStrobe,
  input  logic [31:0]       OutData,
  input  logic [NCH*32-1:0] PerInData,
  input  logic [NCH-1:0]    PerInValid,
  output logic [NCH-1:0]    PerInReady,
  output logic [NCH*32-1:0] PerOutData,
  output logic [NCH-1:0]    PerOutValid,
  input  logic [NCH-1:0]    PerOutReady
);

  logic [3:0]            sel;
  logic                  unused_addr_hi;
  logic                  is_stat;
  logic                  status_clr;
  logic [NCH-1:0]        chan_hit;
  logic [NCH-1:0]        in_pop;
  logic [NCH-1:0]        out_push;
  logic [NCH-1:0]        in_empty;
  logic [NCH-1:0]        in_full;
  logic [NCH-1:0]        out_empty;
  logic [NCH-1:0]        out_full;
  logic [NCH-1:0]        ovf_set;
  logic [NCH-1:0]        unf_set;
  logic [NCH-1:0]        ovf;
  logic [NCH-1:0]        unf;
  logic [NCH-1:0][31:0]  in_head;
  logic [31:0]           status;

  assign sel            = IOaddr[3:0];
  assign unused_addr_hi = ^IOaddr[31:4];

  always_comb begin
    chan_hit = '0;
    for (int c = 0; c < NCH; c++) chan_hit[c] = (sel == 4'(c));
  end

  assign is_stat    = (sel == STATUS_ADDR) && (chan_hit == '0);
  assign status_clr = InStrobe && is_stat;
  assign in_pop     = {NCH{InStrobe}} & chan_hit;
  assign out_push   = {NCH{OutStrobe}} & chan_hit;
  assign unf_set    = in_pop & in_empty;
  assign ovf_set    = out_push & out_full;

  // A status read clears the sticky flags, but a set in the same cycle wins.
  always_ff @(posedge Ph0 or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf <= '0;
      unf <= '0;
    end else begin
      ovf <= (ovf & ~{NCH{status_clr}}) | ovf_set;
      unf <= (unf & ~{NCH{status_clr}}) | unf_set;
    end
  end

  always_comb begin
    status = '0;
    status[NONEMPTY_LSB +: NCH] = ~in_empty;
    status[NOTFULL_LSB  +: NCH] = ~out_full;
    status[OVF_LSB      +: NCH] = ovf;
    status[UNF_LSB      +: NCH] = unf;
  end

  always_comb begin
    InData = '0;
    InRdy  = 1'b0;
    if (is_stat) begin
      InData = status;
      InRdy  = 1'b1;
    end
    for (int c = 0; c < NCH; c++) begin
      if (chan_hit[c]) begin
        InData = in_head[c];
        InRdy  = !in_empty[c];
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    tinycomp_io_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_in_fifo (
      .clk       (Ph0),
      .rst_n     (Reset_n),
      .push      (PerInValid[c]),
      .push_data (PerInData[32*c +: 32]),
      .pop       (in_pop[c]),
      .head      (in_head[c]),
      .full      (in_full[c]),
      .empty     (in_empty[c])
    );

    tinycomp_io_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_out_fifo (
      .clk       (Ph0),
      .rst_n     (Reset_n),
      .push      (out_push[c]),
      .push_data (OutData),
      .pop       (PerOutReady[c]),
      .head      (PerOutData[32*c +: 32]),
      .full      (out_full[c]),
      .empty     (out_empty[c])
    );

    assign PerInReady[c]  = !in_full[c];
    assign PerOutValid[c] = !out_empty[c];
  end

endmodule

// File: tb/tb_tinycomp_io_ctrl.sv
// Self-checking bench for tinycomp_io_ctrl: a directed vector table, directed
// corner sequences and random traffic against a queue-based reference model.
module tb_tinycomp_io_ctrl;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;

  logic              Ph0 = 1'b0;
  logic              Reset_n = 1'b0;
  logic [31:0]       IOaddr = '0;
  logic              InStrobe = 1'b0;
  logic [31:0]       InData;
  logic              InRdy;
  logic              OutStrobe = 1'b0;
  logic [31:0]       OutData = '0;
  logic [NCH*32-1:0] PerInData = '0;
  logic [NCH-1:0]    PerInValid = '0;
  logic [NCH-1:0]    PerInReady;
  logic [NCH*32-1:0] PerOutData;
  logic [NCH-1:0]    PerOutValid;
  logic [NCH-1:0]    PerOutReady = '0;

  always #5 Ph0 = ~Ph0;

  tinycomp_io_ctrl #(.NCH(NCH), .DEPTH(DEPTH), .STATUS_ADDR(4'hF)) dut (
    .Ph0(Ph0), .Reset_n(Reset_n), .IOaddr(IOaddr), .InStrobe(InStrobe),
    .InData(InData), .InRdy(InRdy), .OutStrobe(OutStrobe), .OutData(OutData),
    .PerInData(PerInData), .PerInValid(PerInValid), .PerInReady(PerInReady),
    .PerOutData(PerOutData), .PerOutValid(PerOutValid), .PerOutReady(PerOutReady)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the FIFOs are plain queues, the flags plain bits.
  logic [31:0]    m_in  [NCH][$];
  logic [31:0]    m_out [NCH][$];
  logic [NCH-1:0] m_ovf = '0;
  logic [NCH-1:0] m_unf = '0;

  typedef struct {
    logic [3:0]  addr;
    logic        instr;
    logic        outstr;
    logic [31:0] odata;
    logic [1:0]  pinv;
    logic [31:0] pdata;
    logic [31:0] exp_data;
    logic        exp_rdy;
    logic [1:0]  exp_pinrdy;
    logic [1:0]  exp_poutv;
  } vec_t;

  vec_t vecs [13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelStatus();
    logic [31:0] s = '0;
    for (int c = 0; c < NCH; c++) begin
      s[c]      = (m_in[c].size() != 0);
      s[8 + c]  = (m_out[c].size() < DEPTH);
      s[16 + c] = m_ovf[c];
      s[24 + c] = m_unf[c];
    end
    return s;
  endfunction

  task automatic modelClear();
    for (int c = 0; c < NCH; c++) begin
      m_in[c].delete();
      m_out[c].delete();
    end
    m_ovf = '0;
    m_unf = '0;
  endtask

  // Expected combinational outputs from the current model state and inputs.
  task automatic modelCheck();
    logic [3:0]  s = IOaddr[3:0];
    logic [31:0] ed = '0;
    logic        er = 1'b0;
    if (s < NCH) begin
      if (m_in[s].size() != 0) begin
        ed = m_in[s][0];
        er = 1'b1;
      end
    end else if (s == 4'hF) begin
      ed = modelStatus();
      er = 1'b1;
    end
    checkOutput("indata", InData, ed);
    checkOutput("inrdy", 32'(InRdy), 32'(er));
    for (int c = 0; c < NCH; c++) begin
      checkOutput("perinready", 32'(PerInReady[c]), (m_in[c].size() < DEPTH) ? 32'd1 : 32'd0);
      checkOutput("peroutvalid", 32'(PerOutValid[c]), (m_out[c].size() != 0) ? 32'd1 : 32'd0);
      if (m_out[c].size() != 0) checkOutput("perouthead", PerOutData[32*c +: 32], m_out[c][0]);
    end
  endtask

  // Clock-edge update: every decision uses the state before the edge.
  task automatic modelUpdate();
    logic [3:0] s = IOaddr[3:0];
    logic clr = InStrobe && (s == 4'hF);
    for (int c = 0; c < NCH; c++) begin
      logic hit, in_pop, in_push, out_push, out_pop, unf_set, ovf_set;
      hit      = (s == 4'(c));
      in_pop   = InStrobe && hit && (m_in[c].size() != 0);
      unf_set  = InStrobe && hit && (m_in[c].size() == 0);
      in_push  = PerInValid[c] && (m_in[c].size() < DEPTH);
      out_push = OutStrobe && hit && (m_out[c].size() < DEPTH);
      ovf_set  = OutStrobe && hit && (m_out[c].size() == DEPTH);
      out_pop  = PerOutReady[c] && (m_out[c].size() != 0);
      if (in_pop)   void'(m_in[c].pop_front());
      if (in_push)  m_in[c].push_back(PerInData[32*c +: 32]);
      if (out_pop)  void'(m_out[c].pop_front());
      if (out_push) m_out[c].push_back(OutData);
      m_unf[c] = (m_unf[c] && !clr) || unf_set;
      m_ovf[c] = (m_ovf[c] && !clr) || ovf_set;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic instr, input logic outstr,
                               input logic [31:0] odata, input logic [1:0] pinv,
                               input logic [31:0] pd0, input logic [31:0] pd1,
                               input logic [1:0] pore);
    IOaddr      = addr;
    InStrobe    = instr;
    OutStrobe   = outstr;
    OutData     = odata;
    PerInValid  = pinv;
    PerInData   = {pd1, pd0};
    PerOutReady = pore;
    @(negedge Ph0);
    modelCheck();
    modelUpdate();
    @(posedge Ph0);
    #1;
  endtask

  task automatic idleInputs();
    IOaddr = '0; InStrobe = 1'b0; OutStrobe = 1'b0; OutData = '0;
    PerInValid = '0; PerInData = '0; PerOutReady = '0;
  endtask

  // Asynchronous reset asserted mid-cycle; held across an edge, released away from edges.
  task automatic resetDut();
    idleInputs();
    #1 Reset_n = 1'b0;
    #1;
    checkOutput("rst_perinready", 32'(PerInReady), 32'h3);
    checkOutput("rst_peroutvalid", 32'(PerOutValid), 32'h0);
    checkOutput("rst_ch0_indata", InData, 32'h0);
    checkOutput("rst_ch0_inrdy", 32'(InRdy), 32'h0);
    modelClear();
    @(negedge Ph0);
    @(negedge Ph0);
    Reset_n = 1'b1;
    @(posedge Ph0);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'h1, 1'b0, 1'b0, 32'h0,    2'b10, 32'hA5A5_0001, 32'h0,         1'b0, 2'b11, 2'b00};
    vecs[1]  = '{4'h1, 1'b0, 1'b0, 32'h0,    2'b10, 32'hA5A5_0002, 32'hA5A5_0001, 1'b1, 2'b11, 2'b00};
    vecs[2]  = '{4'h1, 1'b1, 1'b0, 32'h0,    2'b00, 32'h0,         32'hA5A5_0001, 1'b1, 2'b11, 2'b00};
    vecs[3]  = '{4'h1, 1'b1, 1'b0, 32'h0,    2'b00, 32'h0,         32'hA5A5_0002, 1'b1, 2'b11, 2'b00};
    vecs[4]  = '{4'h1, 1'b0, 1'b0, 32'h0,    2'b00, 32'h0,         32'h0,         1'b0, 2'b11, 2'b00};
    vecs[5]  = '{4'hF, 1'b0, 1'b0, 32'h0,    2'b00, 32'h0,         32'h0000_0300, 1'b1, 2'b11, 2'b00};
    vecs[6]  = '{4'h7, 1'b1, 1'b1, 32'hDEAD, 2'b00, 32'h0,         32'h0,         1'b0, 2'b11, 2'b00};
    vecs[7]  = '{4'hF, 1'b0, 1'b0, 32'h0,    2'b00, 32'h0,         32'h0000_0300, 1'b1, 2'b11, 2'b00};
    vecs[8]  = '{4'h0, 1'b1, 1'b0, 32'h0,    2'b00, 32'h0,         32'h0,         1'b0, 2'b11, 2'b00};
    vecs[9]  = '{4'hF, 1'b1, 1'b0, 32'h0,    2'b00, 32'h0,         32'h0100_0300, 1'b1, 2'b11, 2'b00};
    vecs[10] = '{4'hF, 1'b0, 1'b0, 32'h0,    2'b00, 32'h0,         32'h0000_0300, 1'b1, 2'b11, 2'b00};
    vecs[11] = '{4'h0, 1'b0, 1'b1, 32'h11,   2'b00, 32'h0,         32'h0,         1'b0, 2'b11, 2'b00};
    vecs[12] = '{4'hF, 1'b0, 1'b0, 32'h0,    2'b00, 32'h0,         32'h0000_0300, 1'b1, 2'b11, 2'b01};

    #12 Reset_n = 1'b1;
    @(posedge Ph0);
    #1;

    // Directed table: ch1 push/pop, status, unmapped access, underflow, output push.
    for (int i = 0; i < 13; i++) begin
      IOaddr      = {28'h1234567, vecs[i].addr};
      InStrobe    = vecs[i].instr;
      OutStrobe   = vecs[i].outstr;
      OutData     = vecs[i].odata;
      PerInValid  = vecs[i].pinv;
      PerInData   = {vecs[i].pdata, vecs[i].pdata};
      PerOutReady = '0;
      @(negedge Ph0);
      checkOutput($sformatf("vec%0d_indata", i), InData, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_inrdy", i), 32'(InRdy), 32'(vecs[i].exp_rdy));
      checkOutput($sformatf("vec%0d_perinready", i), 32'(PerInReady), 32'(vecs[i].exp_pinrdy));
      checkOutput($sformatf("vec%0d_peroutvalid", i), 32'(PerOutValid), 32'(vecs[i].exp_poutv));
      @(posedge Ph0);
      #1;
    end

    // Reset mid-stream with three entries queued on ch0 and one on output ch1.
    resetDut();
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 2'b01, 32'h1, 32'h0, 2'b00);
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 2'b01, 32'h2, 32'h0, 2'b00);
    applyStimulus(32'h1, 1'b0, 1'b1, 32'h77, 2'b01, 32'h3, 32'h0, 2'b00);
    resetDut();
    IOaddr = 32'hF;
    #1;
    checkOutput("rst_status", InData, 32'h0000_0300);

    // Output overflow on ch0, then drain in order.
    for (int i = 1; i <= 5; i++)
      applyStimulus(32'h0, 1'b0, 1'b1, 32'(i), 2'b00, 32'h0, 32'h0, 2'b00);
    IOaddr = 32'hF;
    #1;
    checkOutput("ovf_status", InData, 32'h0001_0200);
    checkOutput("ovf_perinready", 32'(PerInReady), 32'h3);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain_head", PerOutData[31:0], 32'(i));
      applyStimulus(32'hF, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b01);
    end
    checkOutput("drain_empty", 32'(PerOutValid), 32'h0);
    applyStimulus(32'hF, 1'b1, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("ovf_cleared", InData, 32'h0000_0300);

    // Underflow on empty ch0, then clear through a status read.
    resetDut();
    applyStimulus(32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00);
    IOaddr = 32'hF;
    #1;
    checkOutput("unf_status", InData, 32'h0100_0300);
    applyStimulus(32'hF, 1'b1, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("unf_cleared", InData, 32'h0000_0300);

    // Simultaneous push and pop on ch0 holding two entries, across pointer wrap.
    resetDut();
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 2'b01, 32'd100, 32'h0, 2'b00);
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 2'b01, 32'd101, 32'h0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      checkOutput("wrap_head", InData, 32'(100 + i));
      applyStimulus(32'h0, 1'b1, 1'b0, 32'h0, 2'b01, 32'(102 + i), 32'h0, 2'b00);
    end
    checkOutput("wrap_head_end", InData, 32'd120);
    IOaddr = 32'hF;
    #1;
    checkOutput("wrap_status", InData, 32'h0000_0301);

    // Random traffic against the reference model.
    resetDut();
    for (int n = 0; n < 800; n++) begin
      logic [31:0] a;
      int r;
      a = $urandom();
      r = $urandom_range(0, 5);
      case (r)
        0, 1:    a[3:0] = 4'h0;
        2, 3:    a[3:0] = 4'h1;
        4:       a[3:0] = 4'hF;
        default: a[3:0] = 4'($urandom_range(2, 14));
      endcase
      applyStimulus(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                    2'($urandom_range(0, 3)), $urandom(), $urandom(),
                    2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
